// File: rtl/mips_mem_pkg.sv
// Shared types and constants for the M-stage data-memory access unit.
package mips_mem_pkg;

    localparam int unsigned DMEM_TIMEOUT = 255;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } mem_size_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DONE
    } dmem_state_t;

    // Everything latched at issue; held for the whole transaction.
    typedef struct packed {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
        mem_size_t   size;
        logic        sext;
        logic [1:0]  boff;
    } dmem_req_t;

    function automatic logic misaligned(input mem_size_t size, input logic [1:0] a);
        case (size)
            SZ_BYTE: return 1'b0;
            SZ_HALF: return a[0];
            default: return a != 2'b00;
        endcase
    endfunction

endpackage

// File: rtl/dmem_access_load_align.sv
// Combinational load-data extraction: picks the byte/half lane and extends it.
module load_align
    import mips_mem_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  addr,
    input  mem_size_t   size,
    input  logic        sext,
    output logic [31:0] data
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        byte_v = rdata[7:0];
        case (addr)
            2'd0: byte_v = rdata[7:0];
            2'd1: byte_v = rdata[15:8];
            2'd2: byte_v = rdata[23:16];
            2'd3: byte_v = rdata[31:24];
            default: byte_v = rdata[7:0];
        endcase
        half_v = addr[1] ? rdata[31:16] : rdata[15:0];

        case (size)
            SZ_BYTE: data = {{24{sext & byte_v[7]}}, byte_v};
            SZ_HALF: data = {{16{sext & half_v[15]}}, half_v};
            default: data = rdata;
        endcase
    end

endmodule

// File: rtl/dmem_access.sv
// M-stage data-memory access unit: turns load/store controls into a req/ack
// bus transaction, stalls the pipeline until it completes, then returns load data.
module dmem_access
    import mips_mem_pkg::*;
#(
    parameter int unsigned TIMEOUT = DMEM_TIMEOUT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        m_rmem,
    input  logic        m_wmem,
    input  logic [1:0]  m_size,
    input  logic        m_sext,
    input  logic        m_flush,
    input  logic [31:0] m_aluout,
    input  logic [31:0] m_b,
    output logic [31:0] m_memout,
    output logic        m_mem_stall,
    output logic        m_adel,
    output logic        m_ades,
    output logic        m_buserr,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_be,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_ack
);

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    dmem_state_t state, state_n;
    dmem_req_t   req_q, req_n;
    mem_size_t   size_n;
    logic [7:0]  cnt;
    logic [31:0] cap;
    logic [31:0] ld_data;
    logic        req_v;
    logic        buserr_q;
    logic        pend, mis, start;

    // Reserved size encoding behaves as a word access.
    assign size_n = (m_size == 2'd3) ? SZ_WORD : mem_size_t'(m_size);
    assign pend   = (m_rmem | m_wmem) & ~m_flush;
    assign mis    = misaligned(size_n, m_aluout[1:0]);
    assign m_adel = pend & m_rmem & mis;
    assign m_ades = pend & m_wmem & mis;

    always_comb begin
        req_n       = '0;
        req_n.addr  = {m_aluout[31:2], 2'b00};
        req_n.we    = m_wmem;
        req_n.size  = size_n;
        req_n.sext  = m_sext;
        req_n.boff  = m_aluout[1:0];
        case (size_n)
            SZ_BYTE: begin
                req_n.be    = 4'(4'b0001 << m_aluout[1:0]);
                req_n.wdata = {4{m_b[7:0]}};
            end
            SZ_HALF: begin
                req_n.be    = m_aluout[1] ? 4'b1100 : 4'b0011;
                req_n.wdata = {2{m_b[15:0]}};
            end
            default: begin
                req_n.be    = 4'b1111;
                req_n.wdata = m_b;
            end
        endcase
    end

    always_comb begin
        state_n     = state;
        start       = 1'b0;
        m_mem_stall = 1'b0;
        case (state)
            S_IDLE: begin
                if (pend && !mis) begin
                    start       = 1'b1;
                    m_mem_stall = 1'b1;
                    state_n     = S_BUSY;
                end
            end
            S_BUSY: begin
                m_mem_stall = 1'b1;
                if (dmem_ack || cnt == CNT_LAST) state_n = S_DONE;
            end
            S_DONE:  state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= S_IDLE;
            req_q    <= '0;
            req_v    <= 1'b0;
            cnt      <= 8'd0;
            cap      <= 32'd0;
            buserr_q <= 1'b0;
        end else begin
            state <= state_n;
            if (start) begin
                req_q    <= req_n;
                req_v    <= 1'b1;
                cnt      <= 8'd0;
                cap      <= 32'd0;
                buserr_q <= 1'b0;
            end else if (state == S_BUSY) begin
                // Ack wins over a timeout landing on the same cycle.
                if (dmem_ack) begin
                    cap      <= dmem_rdata;
                    buserr_q <= 1'b0;
                    req_v    <= 1'b0;
                end else if (cnt == CNT_LAST) begin
                    cap      <= 32'd0;
                    buserr_q <= 1'b1;
                    req_v    <= 1'b0;
                end else begin
                    cnt <= cnt + 8'd1;
                end
            end
        end
    end

    load_align u_load_align (
        .rdata (cap),
        .addr  (req_q.boff),
        .size  (req_q.size),
        .sext  (req_q.sext),
        .data  (ld_data)
    );

    assign dmem_req   = req_v;
    assign dmem_we    = req_q.we;
    assign dmem_addr  = req_q.addr;
    assign dmem_wdata = req_q.wdata;
    assign dmem_be    = req_q.be;
    assign m_memout   = (state == S_DONE && !req_q.we) ? ld_data : 32'd0;
    assign m_buserr   = (state == S_DONE) & buserr_q;

endmodule

// File: tb/tb_dmem_access.sv
// Randomized bench for dmem_access with an in-bench transaction-level model.
module tb_dmem_access;

    localparam int TO = 4;

    logic        clk, reset;
    logic        m_rmem, m_wmem, m_sext, m_flush;
    logic [1:0]  m_size;
    logic [31:0] m_aluout, m_b;
    logic [31:0] m_memout;
    logic        m_mem_stall, m_adel, m_ades, m_buserr;
    logic        dmem_req, dmem_we, dmem_ack;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic [3:0]  dmem_be;

    dmem_access #(.TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset),
        .m_rmem(m_rmem), .m_wmem(m_wmem), .m_size(m_size), .m_sext(m_sext),
        .m_flush(m_flush), .m_aluout(m_aluout), .m_b(m_b),
        .m_memout(m_memout), .m_mem_stall(m_mem_stall), .m_adel(m_adel),
        .m_ades(m_ades), .m_buserr(m_buserr),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_be(dmem_be),
        .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- model ----------------
    function automatic logic mis_f(input logic [1:0] sz, input logic [31:0] a);
        if (sz == 2'd0) return 1'b0;
        if (sz == 2'd1) return a[0];
        return a[1:0] != 2'b00;
    endfunction

    function automatic logic [31:0] load_f(input logic [31:0] rd, input logic [31:0] a,
                                           input logic [1:0] sz, input logic sx);
        logic [31:0] v;
        if (sz == 2'd0) begin
            v = (rd >> (8 * a[1:0])) & 32'hFF;
            if (sx && v[7]) v = v | 32'hFFFFFF00;
        end else if (sz == 2'd1) begin
            v = (rd >> (16 * a[1])) & 32'hFFFF;
            if (sx && v[15]) v = v | 32'hFFFF0000;
        end else begin
            v = rd;
        end
        return v;
    endfunction

    function automatic logic [3:0] be_f(input logic [1:0] sz, input logic [31:0] a);
        if (sz == 2'd0) return 4'(1 << a[1:0]);
        if (sz == 2'd1) return a[1] ? 4'hC : 4'h3;
        return 4'hF;
    endfunction

    function automatic logic [31:0] wd_f(input logic [1:0] sz, input logic [31:0] b);
        if (sz == 2'd0) return {24'd0, b[7:0]} * 32'h01010101;
        if (sz == 2'd1) return {16'd0, b[15:0]} * 32'h00010001;
        return b;
    endfunction

    // ---------------- expectations for the current cycle ----------------
    logic        exp_chk = 1'b0;
    logic        exp_stall, exp_req, exp_done, exp_buserr, exp_we;
    logic [31:0] exp_memout, exp_addr, exp_wdata;
    logic [3:0]  exp_be;
    int          txn_id = 0;

    // Observations kept by the compare process for literal checks.
    int          last_id = -1;
    int          req_cnt, stall_cnt;
    logic        seen_adel, seen_ades, d_buserr, b_we;
    logic [31:0] d_memout, b_wdata;
    logic [3:0]  b_be;

    always @(negedge clk) begin
        if (exp_chk) begin
            if (txn_id != last_id) begin
                last_id = txn_id;
                req_cnt = 0; stall_cnt = 0; seen_adel = 0; seen_ades = 0;
            end
            check("stall", m_mem_stall, exp_stall);
            check("req", dmem_req, exp_req);
            check("memout", m_memout, exp_memout);
            check("adel", m_adel, (m_rmem & ~m_flush) & mis_f(m_size, m_aluout));
            check("ades", m_ades, (m_wmem & ~m_flush) & mis_f(m_size, m_aluout));
            if (exp_req) begin
                check("addr", dmem_addr, exp_addr);
                check("we", dmem_we, exp_we);
                check("be", dmem_be, exp_be);
                check("wdata", dmem_wdata, exp_wdata);
            end
            if (exp_done) check("buserr", m_buserr, exp_buserr);
            if (m_mem_stall) stall_cnt++;
            if (dmem_req) begin
                req_cnt++; b_be = dmem_be; b_wdata = dmem_wdata; b_we = dmem_we;
            end
            if (m_adel) seen_adel = 1'b1;
            if (m_ades) seen_ades = 1'b1;
            if (exp_done) begin d_memout = m_memout; d_buserr = m_buserr; end
        end
    end

    // One M-stage instruction; inputs held while stalled, ack after `waits` idle BUSY cycles.
    task automatic run_txn(input logic r, input logic w, input logic [1:0] sz, input logic sx,
                           input logic fl, input logic [31:0] a, input logic [31:0] b,
                           input int waits, input logic [31:0] rd);
        int   nbusy;
        logic tmo;
        @(posedge clk); #1;
        txn_id++;
        m_rmem = r; m_wmem = w; m_size = sz; m_sext = sx; m_flush = fl;
        m_aluout = a; m_b = b;
        dmem_ack = 1'($urandom % 2); dmem_rdata = $urandom;
        exp_chk = 1'b1; exp_req = 1'b0; exp_done = 1'b0; exp_memout = 32'd0;
        if (!((r | w) & ~fl) || mis_f(sz, a)) begin
            exp_stall = 1'b0;
            return;
        end
        exp_stall = 1'b1;
        tmo   = (waits + 1 > TO);
        nbusy = tmo ? TO : waits + 1;
        exp_addr = a & 32'hFFFFFFFC; exp_we = w;
        exp_be = be_f(sz, a); exp_wdata = wd_f(sz, b);
        for (int j = 1; j <= nbusy; j++) begin
            @(posedge clk); #1;
            exp_req = 1'b1;
            dmem_ack = (j == waits + 1);
            dmem_rdata = (j == waits + 1) ? rd : $urandom;
            m_flush = 1'($urandom % 2);
        end
        @(posedge clk); #1;
        exp_req = 1'b0; exp_stall = 1'b0; exp_done = 1'b1; exp_buserr = tmo;
        exp_memout = (w || tmo) ? 32'd0 : load_f(rd, a, sz, sx);
        dmem_ack = 1'($urandom % 2); dmem_rdata = $urandom;
    endtask

    task automatic settle();
        @(negedge clk); #1;
    endtask

    initial begin
        reset = 1'b1;
        m_rmem = 0; m_wmem = 0; m_size = 0; m_sext = 0; m_flush = 0;
        m_aluout = 0; m_b = 0; dmem_ack = 0; dmem_rdata = 0;
        #12;
        check("rst_req", dmem_req, 0);
        check("rst_stall", m_mem_stall, 0);
        check("rst_memout", m_memout, 0);
        check("rst_addr", dmem_addr, 0);
        check("rst_wdata", dmem_wdata, 0);
        check("rst_be", dmem_be, 0);
        check("rst_we", dmem_we, 0);
        check("rst_buserr", m_buserr, 0);
        @(negedge clk); reset = 1'b0;

        run_txn(1, 0, 2, 0, 0, 32'h100, 0, 0, 32'hDEADBEEF); settle();
        check("lit_word_memout", d_memout, 32'hDEADBEEF);
        check("lit_word_req", req_cnt, 1);
        check("lit_word_stall", stall_cnt, 2);

        run_txn(1, 0, 0, 1, 0, 32'h103, 0, 1, 32'h80112233); settle();
        check("lit_lb_sext", d_memout, 32'hFFFFFF80);
        run_txn(1, 0, 0, 0, 0, 32'h103, 0, 0, 32'h80112233); settle();
        check("lit_lbu", d_memout, 32'h00000080);

        run_txn(0, 1, 1, 0, 0, 32'h202, 32'h0000ABCD, 3, 32'h0); settle();
        check("lit_sh_be", b_be, 4'b1100);
        check("lit_sh_wdata", b_wdata, 32'hABCDABCD);
        check("lit_sh_we", b_we, 1);
        check("lit_sh_req", req_cnt, 4);

        run_txn(1, 0, 2, 0, 0, 32'h101, 0, 0, 32'h0); settle();
        check("lit_adel", seen_adel, 1);
        check("lit_adel_req", req_cnt, 0);
        check("lit_adel_stall", stall_cnt, 0);
        run_txn(0, 1, 1, 0, 0, 32'h001, 32'h1234, 0, 32'h0); settle();
        check("lit_ades", seen_ades, 1);

        run_txn(1, 0, 2, 0, 0, 32'h300, 0, 10, 32'h12345678); settle();
        check("lit_tmo_req", req_cnt, TO);
        check("lit_tmo_buserr", d_buserr, 1);
        check("lit_tmo_memout", d_memout, 0);

        run_txn(1, 0, 2, 0, 1, 32'h400, 0, 0, 32'h55AA55AA); settle();
        check("lit_flush_req", req_cnt, 0);
        check("lit_flush_stall", stall_cnt, 0);

        // Asynchronous reset while BUSY.
        @(posedge clk); #1;
        exp_chk = 1'b0;
        m_rmem = 1; m_wmem = 0; m_size = 2; m_flush = 0; m_aluout = 32'h500; dmem_ack = 0;
        @(posedge clk); #1;
        check("rst_busy_pre_req", dmem_req, 1);
        @(posedge clk); #2;
        reset = 1'b1; m_rmem = 0; #1;
        check("rst_busy_req", dmem_req, 0);
        check("rst_busy_stall", m_mem_stall, 0);
        check("rst_busy_addr", dmem_addr, 0);
        check("rst_busy_be", dmem_be, 0);
        @(negedge clk); reset = 1'b0;

        for (int n = 0; n < 200; n++) begin
            int          kind;
            logic [1:0]  sz;
            logic [31:0] a;
            kind = $urandom % 3;
            sz   = 2'($urandom % 4);
            a    = $urandom;
            if ($urandom % 4 != 0) begin
                if (sz == 2'd1) a[0] = 1'b0;
                else if (sz != 2'd0) a[1:0] = 2'b00;
            end
            run_txn(kind == 0, kind == 1, sz, 1'($urandom % 2), ($urandom % 8) == 0,
                    a, $urandom, $urandom_range(0, 5), $urandom);
        end
        settle();
        exp_chk = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
